// File: rtl/ps2_keypad_if.sv
// Scancode input and key-event output handshake for ps2_keypad.
// master = host/consumer side, slave = keypad side.
interface ps2_keypad_if;
   logic       scan_valid;
   logic [7:0] scan_data;
   logic       evt_valid;
   logic [4:0] evt_key;
   logic       evt_ready;

   modport master (
      output scan_valid, scan_data, evt_ready,
      input  evt_valid, evt_key
   );

   modport slave (
      input  scan_valid, scan_data, evt_ready,
      output evt_valid, evt_key
   );
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 scancode parser with programmable key map, held-key matrix and key-down event FIFO.
// Define PS2_KEYPAD_EXT_EN to support E0-prefixed (extended) scancodes.
module ps2_keypad #(
   parameter int unsigned NUM_KEYS   = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                res,
   ps2_keypad_if.slave         bus,
   input  logic                map_we,
   input  logic [4:0]          map_key,
   input  logic [8:0]          map_code,
   output logic [NUM_KEYS-1:0] key_matrix,
   output logic                any_key,
   output logic                overflow,
   input  logic                ovf_clr
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam logic [7:0]  B_BRK = 8'hF0;
   localparam logic [7:0]  B_EXT = 8'hE0;
   localparam logic [7:0]  DEF_CODES [16] = '{
      8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
      8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A
   };

`ifdef PS2_KEYPAD_EXT_EN
   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
   localparam logic [8:0] CMP_MASK = 9'h1FF;
`else
   typedef enum logic [1:0] {IDLE, BRK} state_t;
   localparam logic [8:0] CMP_MASK = 9'h0FF;
`endif

   state_t                state_q, state_d;
   logic                  discard;
   logic                  is_make, is_brk, is_ext;
   logic [8:0]            key_code;
   logic [8:0]            map_q [NUM_KEYS];
   logic [NUM_KEYS-1:0]   map_vld;
   logic [NUM_KEYS-1:0]   hit_vec, wr_vec, mat_d;
   logic [4:0]            hit_idx;
   logic                  push, pop, full, do_push, drop;
   logic [4:0]            fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;

   // Protocol bytes (ACK, BAT, echo, resend, pause prefix) never reach the matrix.
   always_comb begin
      discard = (bus.scan_data == 8'hE1) || (bus.scan_data == 8'hFA) ||
                (bus.scan_data == 8'hAA) || (bus.scan_data == 8'hEE) ||
                (bus.scan_data == 8'hFE);
`ifndef PS2_KEYPAD_EXT_EN
      if (bus.scan_data == B_EXT) discard = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      is_make = 1'b0;
      is_brk  = 1'b0;
      is_ext  = 1'b0;
      if (bus.scan_valid) begin
         if (discard) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.scan_data == B_BRK) state_d = BRK;
`ifdef PS2_KEYPAD_EXT_EN
                  else if (bus.scan_data == B_EXT) state_d = EXT;
`endif
                  else is_make = 1'b1;
               end
               BRK: begin
                  is_brk  = 1'b1;
                  state_d = IDLE;
               end
`ifdef PS2_KEYPAD_EXT_EN
               EXT: begin
                  if (bus.scan_data == B_BRK) begin
                     state_d = EXT_BRK;
                  end else begin
                     is_make = 1'b1;
                     is_ext  = 1'b1;
                     state_d = IDLE;
                  end
               end
               EXT_BRK: begin
                  is_brk  = 1'b1;
                  is_ext  = 1'b1;
                  state_d = IDLE;
               end
`endif
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      key_code = {is_ext, bus.scan_data};
      hit_vec  = '0;
      hit_idx  = '0;
      for (int unsigned i = NUM_KEYS; i > 0; i--) begin
         if (map_vld[i-1] && (((map_q[i-1] ^ key_code) & CMP_MASK) == '0)) begin
            hit_vec      = '0;
            hit_vec[i-1] = 1'b1;
            hit_idx      = 5'(i-1);
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_KEYS; i++)
         wr_vec[i] = map_we && (map_key == 5'(i));
   end

   always_comb begin
      push  = is_make && |(hit_vec & ~key_matrix);
      mat_d = (key_matrix | ({NUM_KEYS{is_make}} & hit_vec))
              & ~({NUM_KEYS{is_brk}} & hit_vec) & ~wr_vec;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         key_matrix <= '0;
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (i < 16) begin
               map_q[i]   <= {1'b0, DEF_CODES[i[3:0]]};
               map_vld[i] <= 1'b1;
            end else begin
               map_q[i]   <= '0;
               map_vld[i] <= 1'b0;
            end
         end
      end else begin
         key_matrix <= mat_d;
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (wr_vec[i]) begin
               map_q[i]   <= map_code;
               map_vld[i] <= 1'b1;
            end
         end
      end
   end

   assign any_key = |key_matrix;

   // When full, a same-cycle pop frees the slot the push overwrites.
   always_comb begin
      full    = (count == CW'(FIFO_DEPTH));
      pop     = bus.evt_valid && bus.evt_ready;
      do_push = push && (!full || pop);
      drop    = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr] <= hit_idx;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign bus.evt_valid = (count != '0);
   assign bus.evt_key   = bus.evt_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: doc/ps2_keypad.md
PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 16, number of mappable keys (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, key-down event FIFO depth (power of 2, >=2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 res  in  1  reset, asynchronous, active-low.
REQ-005 scan_valid  in  1  one-cycle strobe: scan_data holds a received PS/2 byte.
REQ-006 scan_data  in  8  PS/2 scancode byte.
REQ-007 map_we  in  1  write map entry this cycle.
REQ-008 map_key  in  5  key index of map write.
REQ-009 map_code  in  9  {extended flag, scancode} for map write.
REQ-010 key_matrix  out  NUM_KEYS  held-key bitmap, bit k = key k down.
REQ-011 any_key  out  1  OR of key_matrix.
REQ-012 evt_valid  out  1  FIFO non-empty.
REQ-013 evt_key  out  5  key index at FIFO head.
REQ-014 evt_ready  in  1  consumer pops head when evt_valid & evt_ready.
REQ-015 overflow  out  1  sticky: an event was dropped.
REQ-016 ovf_clr  in  1  clears overflow.

Function
REQ-017 Parser FSM states IDLE, BRK, EXT, EXT_BRK; advances only on scan_valid.
REQ-018 IDLE: F0->BRK, E0->EXT, other byte = make code (ext=0), stay IDLE.
REQ-019 EXT: F0->EXT_BRK, other byte = make code (ext=1) ->IDLE; BRK: byte = break code (ext=0) ->IDLE; EXT_BRK: byte = break code (ext=1) ->IDLE.
REQ-020 E1 and FA/AA/EE/FE bytes SHALL be discarded and force IDLE without matrix change.
REQ-021 Lookup: compare {ext,code} with all NUM_KEYS map entries; lowest matching index wins; no match = no effect.
REQ-022 Make: key_matrix[k] set one cycle after scan_valid; break: cleared one cycle after.
REQ-023 Event push only on key_matrix[k] 0->1 transition; typematic repeats push nothing.
REQ-024 evt_valid asserts cycle after push into empty FIFO; events popped in push order.
REQ-025 Push to full FIFO without same-cycle pop SHALL drop event and set overflow next cycle.
REQ-026 Push and pop in same cycle when full: both occur, no overflow; when empty: push only.
REQ-027 ovf_clr and simultaneous drop: overflow remains set (set wins).
REQ-028 map_we with map_key < NUM_KEYS writes entry and clears key_matrix[map_key]; map_key >= NUM_KEYS ignored.
REQ-029 map_we coincident with scan_valid: lookup uses pre-write map.
REQ-030 FSM, matrix, FIFO and map SHALL be sized by parameters only; unused map storage above NUM_KEYS not present.

Reset
REQ-031 On res low: FSM IDLE, key_matrix 0, any_key 0, FIFO empty, evt_valid 0, evt_key 0, overflow 0.
REQ-032 Reset loads map entries 0..F with non-extended 22,16,1E,26,15,1D,24,1C,1B,23,1A,21,25,2D,2B,2A; entries >=16 invalid (never match).
REQ-033 Reset asserted mid-sequence (e.g. after F0) SHALL discard partial state; next byte parsed from IDLE.

Configuration
REQ-034 Macro PS2_KEYPAD_EXT_EN defined: EXT/EXT_BRK states and ext map bit implemented as above.
REQ-035 Undefined: E0 byte discarded, EXT states absent, map ext bit ignored, byte after E0 parsed as non-extended.

Verification
REQ-036 Bytes 16 -> key_matrix=0x0002, evt_valid=1, evt_key=1; then F0,16 -> key_matrix=0x0000.
REQ-037 Bytes 16,16,16 (repeat) -> exactly one event; pop -> evt_valid=0.
REQ-038 Five distinct makes (22,16,1E,26,15) no pops, depth 4 -> overflow=1, pops yield 0,1,2,3.
REQ-039 map_we key 3 code {1,75}; bytes E0,75 -> key_matrix bit3=1; byte 75 alone -> no change (EXT_EN defined).
REQ-040 Bytes F0 then res pulse low, then 16 -> key 1 set (make, not break).
REQ-041 FIFO full, push+pop same cycle -> overflow stays 0, occupancy stays 4.
